control_unit: RTL
=================

# control_unit

Multi-cycle instruction sequencer placed directly upstream of `dataPath`. Each cycle it turns the instruction fetched at the current PC into the full `dataPath` control word: register addresses, ALU function, immediate, bus enables, RAM strobes and the PC-select code `PS`. It latches one 32-bit instruction per fetch into an internal IR. It then walks a small FSM so that ALU, load/store and branch instructions meet the RAM's one-cycle read latency.

## Interface
Parameters:
- `DW`, 64: datapath/immediate width (`K`).
- `IW`, 32: instruction width.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: asynchronous, active-low.
- `instr`  input  IW: instruction-memory output at the current PC.
- `status`  input  4: {V,C,N,Z} from the ALU, combinational, same cycle.
- `write`  output  1: register-file write enable.
- `rdAddrA`, `rdAddrB`, `wrAddr`  output  5 each: register addresses. R31 reads as zero.
- `FS`  output  5: ALU function select.
- `C_in`  output  1: ALU carry-in.
- `K`  output  DW: sign-extended immediate.
- `B_sel`  output  1: 1 = ALU B operand is `K`; 0 = register B.
- `EN_ALU`, `EN_B`, `EN_RAM`  output  1 each: one-hot data-bus source enables.
- `ramWrite`, `ramOut`  output  1 each: RAM write strobe and RAM output enable.
- `PS`  output  2: 00 hold, 01 PC+4, 10 PC+(K<<2), 11 reserved (never driven).
- `halted`  output  1: high once HALT has executed.

## Operation
- IR format: op[31:24], DA[23:19], SA[18:14], SB[13:9], imm9[8:0]. `K` = sign-extend(imm9) to DW.
- Opcodes: ADD 0x01, SUB 0x02, AND 0x03, OR 0x04, ADDI 0x05, LDR 0x10, STR 0x11, B 0x20, CBZ 0x21, HALT 0xFF. Any other opcode is a NOP: one EXEC cycle, `PS`=01, no writes.
- States: FETCH, EXEC, MEM_A, MEM_D, HALT.
- FETCH: IR <= `instr`. All outputs are idle: strobes 0, `PS`=00. Next state is EXEC.
- EXEC, R-type (ADD/SUB/AND/OR):
  - rdAddrA=SA, rdAddrB=SB, wrAddr=DA, `B_sel`=0, `EN_ALU`=1.
  - `write`=1 unless DA=31. `PS`=01. Next state is FETCH.
  - SUB sets `C_in`=1 with FS_SUB.
- EXEC, ADDI: as R-type with `B_sel`=1 and FS_ADD.
- EXEC, LDR/STR: drives the address phase (A=SA, `B_sel`=1, FS_ADD, `EN_RAM`=1). `PS`=00. Next state is MEM_A.
- MEM_A:
  - STR: rdAddrB=DA, `ramWrite`=1.
  - LDR: `ramOut`=0, RAM read is launched.
  - Both: `PS`=00. Next state is MEM_D.
- MEM_D:
  - LDR: `ramOut`=1, `EN_RAM`=1, wrAddr=DA, `write`=1 unless DA=31.
  - Both: `PS`=01. Next state is FETCH.
- B: `PS`=10. Next state is FETCH.
- CBZ: rdAddrA=DA, FS_PASS_A, `EN_ALU`=1. `PS`=10 if `status`[0] (Z) is 1, else `PS`=01.
- HALT: `PS`=00, all strobes 0, `halted`=1. Stays in HALT until reset.
- At most one of `EN_ALU`/`EN_B`/`EN_RAM` is high in any cycle.
- `write` and `ramWrite` are never high in the same cycle.

## Timing
- Reset (async assert, sync release): state=FETCH, IR=0, `halted`=0. Every output is 0, including `PS`=00 and `K`=0.
- Outputs are combinational from state and IR (Moore on IR); no output depends on `instr` directly.
- Latency per instruction:
  - ALU, ADDI, B, CBZ, NOP: 2 cycles.
  - LDR, STR: 4 cycles.
  - The PC advances exactly once per instruction, on the cycle `PS`≠00.
- CBZ samples Z in the EXEC cycle only.
- Reset asserted mid-instruction (e.g. in MEM_A of STR) drops `ramWrite` immediately. No partial write is repeated after release.
- A branch offset of 0 (`PS`=10, `K`=0) is legal and re-executes the same instruction.

## Structure
- Package `cu_pkg`:
  - Opcode localparams.
  - State enum encoding (FETCH=0, EXEC=1, MEM_A=2, MEM_D=3, HALT=4).
  - FS constants: FS_PASS_A=5'd0, FS_ADD=5'd4, FS_SUB=5'd5, FS_AND=5'd8, FS_OR=5'd12.
  - PS constants.
- Sub-module `cu_decode`: purely combinational map from (state, IR, Z) to the control word. The top holds only the IR, the state register and `halted`.

## Test plan
- Reset, then IR=ADDI DA=0 SA=31 imm=1: in EXEC, `write`=1, wrAddr=0, `K`=1, `B_sel`=1, FS=4, `PS`=01. All outputs are 0 during reset.
- ADD DA=2 SA=0 SB=1: 2 cycles, `B_sel`=0, `write`=1 only in EXEC. ADD with DA=31 gives `write`=0.
- STR DA=1 SA=0 imm=1: sequence FETCH, EXEC, MEM_A (`ramWrite`=1, rdAddrB=1), MEM_D. `PS`=01 only in the last cycle.
- LDR DA=7 SA=0 imm=1: `ramOut`=1, `write`=1, wrAddr=7 in MEM_D only. Total 4 cycles.
- CBZ imm=−2 with Z=1 gives `PS`=10, `K`=0xFFFF_FFFF_FFFF_FFFE. With Z=0 it gives `PS`=01. Opcode 0x7E behaves as NOP with `PS`=01.
- HALT: `halted`=1 and `PS`=00 held for 10 cycles. Reset pulsed during MEM_A of STR forces `ramWrite`=0 asynchronously and state=FETCH.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared opcodes, FSM state encoding, ALU function and PC-select codes for the
// control unit, plus the packed control word handed from decoder to top.
package cu_pkg;

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_AND  = 8'h03;
  localparam logic [7:0] OP_OR   = 8'h04;
  localparam logic [7:0] OP_ADDI = 8'h05;
  localparam logic [7:0] OP_LDR  = 8'h10;
  localparam logic [7:0] OP_STR  = 8'h11;
  localparam logic [7:0] OP_B    = 8'h20;
  localparam logic [7:0] OP_CBZ  = 8'h21;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM_A = 3'd2,
    ST_MEM_D = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [4:0] FS_PASS_A = 5'd0;
  localparam logic [4:0] FS_ADD    = 5'd4;
  localparam logic [4:0] FS_SUB    = 5'd5;
  localparam logic [4:0] FS_AND    = 5'd8;
  localparam logic [4:0] FS_OR     = 5'd12;

  localparam logic [1:0] PS_HOLD   = 2'b00;
  localparam logic [1:0] PS_NEXT   = 2'b01;
  localparam logic [1:0] PS_BRANCH = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd31;

  typedef struct packed {
    logic       write;
    logic [4:0] rd_addr_a;
    logic [4:0] rd_addr_b;
    logic [4:0] wr_addr;
    logic [4:0] fs;
    logic       c_in;
    logic       b_sel;
    logic       en_alu;
    logic       en_b;
    logic       en_ram;
    logic       ram_write;
    logic       ram_out;
    logic [1:0] ps;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [7:0] op);
    return (op == OP_LDR) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational map from (state, IR, Z) to the dataPath control word.
// FETCH and HALT produce an all-zero word, so reset leaves every output idle.
module cu_decode
  import cu_pkg::*;
#(
  parameter int DW = 64,
  parameter int IW = 32
) (
  input  state_t          state,
  input  logic [IW-1:0]   ir,
  input  logic            z,
  output ctrl_t           ctrl,
  output logic [DW-1:0]   k
);

  logic [7:0]    op;
  logic [4:0]    da;
  logic [4:0]    sa;
  logic [4:0]    sb;
  logic [DW-1:0] k_ext;

  assign op    = ir[31:24];
  assign da    = ir[23:19];
  assign sa    = ir[18:14];
  assign sb    = ir[13:9];
  assign k_ext = {{(DW-9){ir[8]}}, ir[8:0]};

  always_comb begin
    ctrl = '0;
    k    = '0;
    case (state)
      ST_EXEC: begin
        k = k_ext;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
            ctrl.rd_addr_a = sa;
            ctrl.rd_addr_b = (op == OP_ADDI) ? 5'd0 : sb;
            ctrl.wr_addr   = da;
            ctrl.b_sel     = (op == OP_ADDI);
            ctrl.en_alu    = 1'b1;
            ctrl.write     = (da != REG_ZERO);
            ctrl.c_in      = (op == OP_SUB);
            ctrl.ps        = PS_NEXT;
            case (op)
              OP_SUB:  ctrl.fs = FS_SUB;
              OP_AND:  ctrl.fs = FS_AND;
              OP_OR:   ctrl.fs = FS_OR;
              default: ctrl.fs = FS_ADD;
            endcase
          end
          OP_LDR, OP_STR: begin
            // Address phase: SA + K onto the RAM address bus.
            ctrl.rd_addr_a = sa;
            ctrl.b_sel     = 1'b1;
            ctrl.fs        = FS_ADD;
            ctrl.en_ram    = 1'b1;
            ctrl.ps        = PS_HOLD;
          end
          OP_B: ctrl.ps = PS_BRANCH;
          OP_CBZ: begin
            ctrl.rd_addr_a = da;
            ctrl.fs        = FS_PASS_A;
            ctrl.en_alu    = 1'b1;
            ctrl.ps        = z ? PS_BRANCH : PS_NEXT;
          end
          OP_HALT: ctrl.ps = PS_HOLD;
          default: ctrl.ps = PS_NEXT;
        endcase
      end
      ST_MEM_A: begin
        k              = k_ext;
        ctrl.rd_addr_a = sa;
        ctrl.b_sel     = 1'b1;
        ctrl.fs        = FS_ADD;
        if (op == OP_STR) begin
          ctrl.rd_addr_b = da;
          ctrl.ram_write = 1'b1;
        end
      end
      ST_MEM_D: begin
        k              = k_ext;
        ctrl.rd_addr_a = sa;
        ctrl.b_sel     = 1'b1;
        ctrl.fs        = FS_ADD;
        ctrl.ps        = PS_NEXT;
        if (op == OP_LDR) begin
          ctrl.ram_out = 1'b1;
          ctrl.en_ram  = 1'b1;
          ctrl.wr_addr = da;
          ctrl.write   = (da != REG_ZERO);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: holds IR, FSM state and the halted flag;
// all control outputs come from cu_decode so they never see instr directly.
module control_unit
  import cu_pkg::*;
#(
  parameter int DW = 64,
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] instr,
  input  logic [3:0]    status,
  output logic          write,
  output logic [4:0]    rdAddrA,
  output logic [4:0]    rdAddrB,
  output logic [4:0]    wrAddr,
  output logic [4:0]    FS,
  output logic          C_in,
  output logic [DW-1:0] K,
  output logic          B_sel,
  output logic          EN_ALU,
  output logic          EN_B,
  output logic          EN_RAM,
  output logic          ramWrite,
  output logic          ramOut,
  output logic [1:0]    PS,
  output logic          halted
);

  state_t        state_reg;
  logic [IW-1:0] ir_reg;
  logic          halted_reg;
  ctrl_t         ctrl;
  logic          unused_status;

  // Only Z matters here; V, C and N are carried for future branch types.
  assign unused_status = ^status[3:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_FETCH;
      ir_reg     <= '0;
      halted_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          ir_reg    <= instr;
          state_reg <= ST_EXEC;
        end
        ST_EXEC: begin
          if (is_mem_op(ir_reg[31:24])) begin
            state_reg <= ST_MEM_A;
          end else if (ir_reg[31:24] == OP_HALT) begin
            state_reg  <= ST_HALT;
            halted_reg <= 1'b1;
          end else begin
            state_reg <= ST_FETCH;
          end
        end
        ST_MEM_A: state_reg <= ST_MEM_D;
        ST_MEM_D: state_reg <= ST_FETCH;
        ST_HALT:  state_reg <= ST_HALT;
        default:  state_reg <= ST_FETCH;
      endcase
    end
  end

  cu_decode #(
    .DW(DW),
    .IW(IW)
  ) u_decode (
    .state(state_reg),
    .ir   (ir_reg),
    .z    (status[0]),
    .ctrl (ctrl),
    .k    (K)
  );

  assign write    = ctrl.write;
  assign rdAddrA  = ctrl.rd_addr_a;
  assign rdAddrB  = ctrl.rd_addr_b;
  assign wrAddr   = ctrl.wr_addr;
  assign FS       = ctrl.fs;
  assign C_in     = ctrl.c_in;
  assign B_sel    = ctrl.b_sel;
  assign EN_ALU   = ctrl.en_alu;
  assign EN_B     = ctrl.en_b;
  assign EN_RAM   = ctrl.en_ram;
  assign ramWrite = ctrl.ram_write;
  assign ramOut   = ctrl.ram_out;
  assign PS       = ctrl.ps;
  assign halted   = halted_reg;

endmodule
